// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the NOP instruction, and the register-dependency compare.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // x0 is hard-wired to zero, so a load targeting it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic       use_rs);
    return use_rs && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear, used for pipeline performance stats.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipe-register sequencer: load-use stalls, branch redirects, data-memory wait
// freezes with timeout, plus saturating stall/flush counters.
//
// state    | meaning
// RUN      | normal issue; stage rules apply unless a memory access starts waiting
// MEM_WAIT | data memory busy; whole pipe frozen until dmem_ready
// ERR      | memory wait exceeded MEM_TIMEOUT; permanent freeze until reset
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err;
  logic              freeze;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;

  always_comb begin
    load_use = ex_mem_read &&
               (reg_match(ex_rd_addr, id_rs1_addr, id_use_rs1) ||
                reg_match(ex_rd_addr, id_rs2_addr, id_use_rs2));

    case (state)
      RUN:      freeze = mem_access && !dmem_ready;
      MEM_WAIT: freeze = !dmem_ready;
      default:  freeze = 1'b1;
    endcase
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;

    if (!rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      // A branch held in EX during a freeze is acted on only at release.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign stall_inc       = rst && !pc_write;
  assign flush_inc       = rst && !freeze && ex_branch_taken;
  assign mem_timeout_err = err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (!rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default-parameter instance for the main
// behaviour, small instance (MEM_TIMEOUT=4, CNT_W=3) for timeout and saturation.
module tb_pipe_hazard_ctrl;

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble}
  localparam logic [6:0] CTL_RUN = 7'b1101010;
  localparam logic [6:0] CTL_RST = 7'b0010101;
  localparam logic [6:0] CTL_FRZ = 7'b0000001;
  localparam logic [6:0] CTL_BR  = 7'b1111110;
  localparam logic [6:0] CTL_LU  = 7'b0001110;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       mrd;
    logic [4:0] rd;
    logic       br;
    logic       macc;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write, a_id_ex_flush;
  logic        a_ex_mem_write, a_mem_wb_bubble, a_err;
  logic [15:0] a_stall, a_flush;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write, b_id_ex_flush;
  logic        b_ex_mem_write, b_mem_wb_bubble, b_err;
  logic [2:0]  b_stall, b_flush;
  logic [6:0]  a_ctl, b_ctl;

  assign a_ctl = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write,
                  a_id_ex_flush, a_ex_mem_write, a_mem_wb_bubble};
  assign b_ctl = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write,
                  b_id_ex_flush, b_ex_mem_write, b_mem_wb_bubble};

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
    .id_ex_write(a_id_ex_write), .id_ex_flush(a_id_ex_flush),
    .ex_mem_write(a_ex_mem_write), .mem_wb_bubble(a_mem_wb_bubble),
    .mem_timeout_err(a_err), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_ex_write(b_id_ex_write), .id_ex_flush(b_id_ex_flush),
    .ex_mem_write(b_ex_mem_write), .mem_wb_bubble(b_mem_wb_bubble),
    .mem_timeout_err(b_err), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  int   checks = 0;
  int   errors = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  vec_t vecs[15];

  function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                              input logic u1, input logic u2, input logic mr,
                              input logic [4:0] d, input logic b, input logic ma,
                              input logic rd_y, input logic [6:0] e);
    vec_t v;
    v.rst = r; v.rs1 = s1; v.rs2 = s2; v.use1 = u1; v.use2 = u2; v.mrd = mr;
    v.rd = d; v.br = b; v.macc = ma; v.rdy = rd_y; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_use_rs1 = v.use1; id_use_rs2 = v.use2; ex_mem_read = v.mrd;
    ex_rd_addr = v.rd; ex_branch_taken = v.br; mem_access = v.macc; dmem_ready = v.rdy;
  endtask

  // Checks dut_a controls before the edge, then its counters after it.
  task automatic step(input string name, input logic [6:0] exp);
    #1;
    chk({name, " ctl"}, 32'(a_ctl), 32'(exp));
    @(posedge clk);
    #1;
    if (!rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!exp[6] && m_stall < 65535) m_stall++;
      if (exp == CTL_BR && m_flush < 65535) m_flush++;
    end
    chk({name, " stall_cnt"}, 32'(a_stall), 32'(m_stall));
    chk({name, " flush_cnt"}, 32'(a_flush), 32'(m_flush));
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, CTL_RST);
    vecs[1]  = mk(0, 0, 5, 0, 1, 1, 5, 1, 1, 0, CTL_RST);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, CTL_RST);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, CTL_RUN);
    vecs[4]  = mk(1, 0, 5, 0, 1, 1, 5, 0, 0, 1, CTL_LU);
    vecs[5]  = mk(1, 0, 5, 0, 1, 0, 5, 0, 0, 1, CTL_RUN);
    vecs[6]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, CTL_RUN);
    vecs[7]  = mk(1, 7, 2, 1, 0, 1, 7, 0, 0, 1, CTL_LU);
    vecs[8]  = mk(1, 7, 2, 0, 1, 1, 7, 0, 0, 1, CTL_RUN);
    vecs[9]  = mk(1, 3, 9, 1, 0, 1, 9, 0, 0, 1, CTL_RUN);
    vecs[10] = mk(1, 5, 0, 1, 0, 0, 5, 0, 0, 1, CTL_RUN);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, CTL_BR);
    vecs[12] = mk(1, 0, 5, 0, 1, 1, 5, 1, 0, 1, CTL_BR);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, CTL_RUN);
    vecs[14] = mk(1, 4, 5, 1, 1, 1, 3, 0, 0, 1, CTL_RUN);

    drive(vecs[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      step($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Memory wait with a taken branch held in EX: 4 freezes, release acts on the branch once.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, CTL_FRZ));
    for (int i = 0; i < 4; i++) step($sformatf("wait%0d", i), CTL_FRZ);
    dmem_ready = 1'b1;
    step("wait_release", CTL_BR);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN));
    step("back_in_run", CTL_RUN);

    // Timeout on the small instance.
    rst = 1'b0;
    step("rst2", CTL_RST);
    chk("b_err_cleared", 32'(b_err), 32'd0);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, CTL_FRZ));
    for (int i = 0; i < 5; i++) begin
      step($sformatf("to%0d", i), CTL_FRZ);
      chk($sformatf("b_err_to%0d", i), 32'(b_err), (i == 4) ? 32'd1 : 32'd0);
    end
    mem_access = 1'b0;
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("b_err_freeze%0d", i), 32'(b_ctl), 32'(CTL_FRZ));
      step($sformatf("a_release%0d", i), CTL_RUN);
      chk($sformatf("b_err_sticky%0d", i), 32'(b_err), 32'd1);
    end
    rst = 1'b0;
    #1;
    chk("b_rst_ctl", 32'(b_ctl), 32'(CTL_RST));
    step("rst3", CTL_RST);
    chk("b_err_reset", 32'(b_err), 32'd0);
    rst = 1'b1;
    #1;
    chk("b_after_rst_ctl", 32'(b_ctl), 32'(CTL_RUN));

    // Flush counter saturation on the 3-bit instance.
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step($sformatf("sat%0d", i), CTL_BR);
      chk($sformatf("b_flush_sat%0d", i), 32'(b_flush), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end
    chk("b_stall_after_sat", 32'(b_stall), 32'd0);
    ex_branch_taken = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
